// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_pkg: Gray/binary pointer helpers shared by both FIFO controllers.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fifo_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Both conversions are width-agnostic: callers zero-extend a narrower
  // pointer into gray_word_t and truncate the result back.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wr_ctrl_if: producer / memory / read-pointer bundle of the FIFO     |
// | write-side controller.                                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  import fifo_pkg::*;

  localparam int PTR_W = ptr_width(ADDR_WIDTH);

  logic             wr_req;
  logic [PTR_W-1:0] rd_ptr_gray;
  logic             wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [PTR_W-1:0] wr_ptr_gray;
  logic             full;
  logic             almost_full;
  logic [PTR_W-1:0] wr_count;
  logic             overflow;

  modport master (
    output wr_req, rd_ptr_gray,
    input  wr_en, wr_addr, wr_ptr_gray, full, almost_full, wr_count, overflow
  );

  modport slave (
    input  wr_req, rd_ptr_gray,
    output wr_en, wr_addr, wr_ptr_gray, full, almost_full, wr_count, overflow
  );

endinterface
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_ff: generic STAGES-deep, WIDTH-bit flop synchroniser, sync reset.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

  if (STAGES < 1 || WIDTH < 1) begin : g_bad_params
    $error("sync_ff: STAGES and WIDTH must be at least 1");
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wr_ctrl: write-domain pointer controller of the dual-clock FIFO.    |
// | Gates writes when full, tracks occupancy and a sticky overflow flag.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input logic           clk,
  input logic           rst,
  fifo_wr_ctrl_if.slave bus
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > GRAY_MAX_W - 1) begin : g_bad_addr_width
    $error("fifo_wr_ctrl: ADDR_WIDTH must be in 2..%0d", GRAY_MAX_W - 1);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("fifo_wr_ctrl: SYNC_STAGES must be at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull_thresh
    $error("fifo_wr_ctrl: AFULL_THRESH must be in 1..DEPTH");
  end

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PTR_W-1:0] wr_count_q, wr_count_d;
  logic             full_q, full_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;

  logic [PTR_W-1:0] rq;
  logic [PTR_W-1:0] rq_bin;
  logic [PTR_W-1:0] full_match;
  logic             wr_en;

  sync_ff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_ptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rd_ptr_gray),
    .q   (rq)
  );

  // Full/count use the synchronised read pointer, so they can only be
  // pessimistic: a read is seen late, never early.
  always_comb begin
    wr_en         = bus.wr_req & ~full_q & ~rst;
    wp_d          = wp_q + {{ADDR_WIDTH{1'b0}}, wr_en};
    wr_ptr_gray_d = PTR_W'(bin2gray(GRAY_MAX_W'(wp_d)));
    rq_bin        = PTR_W'(gray2bin(GRAY_MAX_W'(rq)));
    full_match    = {~rq[PTR_W-1:PTR_W-2], rq[PTR_W-3:0]};
    full_d        = (wr_ptr_gray_d == full_match);
    wr_count_d    = wp_d - rq_bin;
    almost_full_d = (wr_count_d >= AFULL_LVL);
    overflow_d    = overflow_q | (bus.wr_req & full_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q          <= '0;
      wr_ptr_gray_q <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wp_q[ADDR_WIDTH-1:0];
  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.wr_count    = wr_count_q;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire
